// File: rtl/e5_pipe_pkg.sv
// e5_pipe_pkg -- shared types for the five-stage RV32 pipeline control.
//   fwd_sel_t  : EX operand forwarding select (register file / ResultW / ResultM)
//   hz_state_t : hazard controller sequencing state
//   REG_IDX_W  : architectural register index width
//   fwd_pick() : forwarding priority for one EX source operand
package e5_pipe_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        RUN   = 2'b01,
        MWAIT = 2'b10
    } hz_state_t;

    // Forward from M first (youngest producer), then W, else read the RF.
    // x0 is hardwired to zero, so a write to it is never forwarded.
    function automatic fwd_sel_t fwd_pick(
        input logic [REG_IDX_W-1:0] rs,
        input logic [REG_IDX_W-1:0] rd_m,
        input logic                 we_m,
        input logic [REG_IDX_W-1:0] rd_w,
        input logic                 we_w
    );
        fwd_sel_t sel;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit -- combinational EX-stage forwarding select generation.
// Ports:
//   Rs1E, Rs2E         in  source registers of the instruction in E
//   RdM, RegWriteM     in  destination / write enable of the instruction in M
//   RdW, RegWriteW     in  destination / write enable of the instruction in W
//   fwd_a_o, fwd_b_o   out operand A / B select (fwd_sel_t)
module hazard_fwd_unit
    import e5_pipe_pkg::*;
(
    input  logic [REG_IDX_W-1:0] Rs1E,
    input  logic [REG_IDX_W-1:0] Rs2E,
    input  logic [REG_IDX_W-1:0] RdM,
    input  logic                 RegWriteM,
    input  logic [REG_IDX_W-1:0] RdW,
    input  logic                 RegWriteW,
    output fwd_sel_t             fwd_a_o,
    output fwd_sel_t             fwd_b_o
);

    // Both operands use the same M-over-W priority.
    always_comb begin
        fwd_a_o = fwd_pick(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        fwd_b_o = fwd_pick(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline sequencing controller for the five-stage RV32 core.
// Generates stall/flush enables for the F/D, D/E, E/M and M/W registers and
// the EX forwarding selects. Stall, flush and forward outputs are
// combinational from the state register and the current inputs so that a
// hazard is handled in the cycle it appears.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   Rs1D, Rs2D                     sources of the instruction in D
//   Rs1E, Rs2E, RdE, MemReadE      sources / destination / load flag in E
//   RdM, RegWriteM                 destination / write enable in M
//   RdW, RegWriteW                 destination / write enable in W
//   PCSrcE                         taken branch or jump resolved in E
//   MemReqM, MemReadyM             data memory request / completion in M
//   StallF/D/E/M                   hold PC / stage registers
//   FlushD/E/W                     bubble into D, E or W register
//   ForwardAE, ForwardBE           00 RF, 01 ResultW, 10 ResultM
//   Busy                           high while clearing the pipe after reset
//   StallCycles, FlushCount        performance counters (HAZARD_PERFCNT_EN)
// Optional feature macro: HAZARD_PERFCNT_EN adds saturating counters.
module hazard_ctrl
    import e5_pipe_pkg::*;
#(
    parameter int STARTUP_CYCLES = 1,
    parameter int CNT_W          = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] Rs1D,
    input  logic [REG_IDX_W-1:0] Rs2D,
    input  logic [REG_IDX_W-1:0] Rs1E,
    input  logic [REG_IDX_W-1:0] Rs2E,
    input  logic [REG_IDX_W-1:0] RdE,
    input  logic                 MemReadE,
    input  logic [REG_IDX_W-1:0] RdM,
    input  logic                 RegWriteM,
    input  logic [REG_IDX_W-1:0] RdW,
    input  logic                 RegWriteW,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 Busy
`ifdef HAZARD_PERFCNT_EN
    ,
    output logic [CNT_W-1:0]     StallCycles,
    output logic [CNT_W-1:0]     FlushCount
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(STARTUP_CYCLES - 1);

    hz_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_stall_s;
    logic       load_use_s;
    logic       branch_flush_s;
    fwd_sel_t   fwd_a_s, fwd_b_s;

    hazard_fwd_unit u_fwd (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .fwd_a_o   (fwd_a_s),
        .fwd_b_o   (fwd_b_s)
    );

    // Hazard detection, output decode and next-state selection.
    always_comb begin
        mem_stall_s    = MemReqM & ~MemReadyM;
        load_use_s     = MemReadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
        branch_flush_s = 1'b0;
        state_d        = state_q;
        cnt_d          = cnt_q;
        StallF         = 1'b0;
        StallD         = 1'b0;
        StallE         = 1'b0;
        StallM         = 1'b0;
        FlushD         = 1'b0;
        FlushE         = 1'b0;
        FlushW         = 1'b0;
        case (state_q)
            INIT: begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushW = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RUN, MWAIT: begin
                if (mem_stall_s) begin
                    // Freeze everything up to M; a branch in E stays held
                    // and flushes once the memory access completes.
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    StallM  = 1'b1;
                    FlushW  = 1'b1;
                    state_d = MWAIT;
                end else begin
                    state_d = RUN;
                    if (PCSrcE) begin
                        FlushD         = 1'b1;
                        FlushE         = 1'b1;
                        branch_flush_s = 1'b1;
                    end else if (load_use_s) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end else begin
                        branch_flush_s = 1'b0;
                    end
                end
            end
            default: begin
                FlushD  = 1'b1;
                FlushE  = 1'b1;
                FlushW  = 1'b1;
                state_d = INIT;
                cnt_d   = CNT_INIT;
            end
        endcase
    end

    // Forwarding is suppressed while the pipe is being cleared.
    always_comb begin
        Busy = (state_q == INIT);
        if (state_q == INIT) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end else begin
            ForwardAE = fwd_a_s;
            ForwardBE = fwd_b_s;
        end
    end

    // Sequencing state and startup counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= CNT_INIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERFCNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating performance counters; INIT cycles are not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q != INIT) && StallF && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (branch_flush_s && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
        end
    end

    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed self-checking bench for hazard_ctrl
// (STARTUP_CYCLES = 3). Inputs change 1 time unit after a rising edge and
// outputs are sampled 1 time unit after that.
module tb_hazard_ctrl;
    import e5_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       MemReadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, Busy;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERFCNT_EN
    logic [31:0] StallCycles, FlushCount;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.STARTUP_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .MemReadE(MemReadE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .Busy(Busy)
`ifdef HAZARD_PERFCNT_EN
        , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        MemReadE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        // Forwarding candidate present while resetting: must be masked.
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        #3;
        check_eq("rst_busy",   32'(Busy),      32'd1);
        check_eq("rst_flushd", 32'(FlushD),    32'd1);
        check_eq("rst_flushe", 32'(FlushE),    32'd1);
        check_eq("rst_flushw", 32'(FlushW),    32'd1);
        check_eq("rst_stallf", 32'(StallF),    32'd0);
        check_eq("rst_fwda",   32'(ForwardAE), 32'd0);

        // ---------------- startup: 3 edges of INIT ----------------
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("init_busy",   32'(Busy),      32'd1);
            check_eq("init_flushe", 32'(FlushE),    32'd1);
            check_eq("init_fwda",   32'(ForwardAE), 32'd0);
            tick();
        end
        #1;
        check_eq("run_busy",   32'(Busy),   32'd0);
        check_eq("run_flushd", 32'(FlushD), 32'd0);
        check_eq("run_flushe", 32'(FlushE), 32'd0);
        check_eq("run_flushw", 32'(FlushW), 32'd0);

        // ---------------- forwarding ----------------
        RdW = 5'd5; RegWriteW = 1'b1;
        #1 check_eq("fwd_a_m", 32'(ForwardAE), 32'd2);
        RdM = 5'd0;
        #1 check_eq("fwd_a_w", 32'(ForwardAE), 32'd1);
        Rs2E = 5'd0; RdW = 5'd0;
        #1 check_eq("fwd_b_rf", 32'(ForwardBE), 32'd0);
        check_eq("fwd_a_rf", 32'(ForwardAE), 32'd0);
        Rs2E = 5'd9; RdM = 5'd9; RdW = 5'd9; RegWriteM = 1'b1;
        #1 check_eq("fwd_b_m", 32'(ForwardBE), 32'd2);
        RegWriteM = 1'b0;
        #1 check_eq("fwd_b_w", 32'(ForwardBE), 32'd1);

        // ---------------- load-use ----------------
        tick();
        idle();
        MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd3;
        #1;
        check_eq("lu_stallf", 32'(StallF), 32'd1);
        check_eq("lu_stalld", 32'(StallD), 32'd1);
        check_eq("lu_flushe", 32'(FlushE), 32'd1);
        check_eq("lu_stalle", 32'(StallE), 32'd0);
        check_eq("lu_flushd", 32'(FlushD), 32'd0);
        tick();
        exp_stall++;
        MemReadE = 1'b0;  // bubble now sits in E
        #1 check_eq("lu_after", 32'(StallF), 32'd0);
        MemReadE = 1'b1; RdE = 5'd0; Rs2D = 5'd0;
        #1;
        check_eq("lu_x0_stallf", 32'(StallF), 32'd0);
        check_eq("lu_x0_flushe", 32'(FlushE), 32'd0);

        // ---------------- memory wait, 3 cycles ----------------
        tick();
        idle();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("mw_stallf", 32'(StallF), 32'd1);
            check_eq("mw_stalle", 32'(StallE), 32'd1);
            check_eq("mw_stallm", 32'(StallM), 32'd1);
            check_eq("mw_flushw", 32'(FlushW), 32'd1);
            check_eq("mw_state", 32'(dut.state_q), (i == 0) ? 32'(RUN) : 32'(MWAIT));
            tick();
            exp_stall++;
        end
        MemReadyM = 1'b1;
        #1;
        check_eq("mw_rdy_stallf", 32'(StallF), 32'd0);
        check_eq("mw_rdy_stallm", 32'(StallM), 32'd0);
        check_eq("mw_rdy_flushw", 32'(FlushW), 32'd0);
        check_eq("mw_rdy_state", 32'(dut.state_q), 32'(MWAIT));
        tick();
        MemReqM = 1'b0;
        #1 check_eq("mw_back_run", 32'(dut.state_q), 32'(RUN));
`ifdef HAZARD_PERFCNT_EN
        check_eq("pc_stall_a", StallCycles, 32'(exp_stall));
`endif

        // ---------------- branch during memory wait ----------------
        MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
        #1;
        check_eq("bmw_flushd", 32'(FlushD), 32'd0);
        check_eq("bmw_flushe", 32'(FlushE), 32'd0);
        check_eq("bmw_stalle", 32'(StallE), 32'd1);
        tick();
        exp_stall++;
        #1;
        check_eq("bmw_flushd2", 32'(FlushD), 32'd0);
        check_eq("bmw_state", 32'(dut.state_q), 32'(MWAIT));
        tick();
        exp_stall++;
        MemReadyM = 1'b1;
        #1;
        check_eq("bmw_rdy_flushd", 32'(FlushD), 32'd1);
        check_eq("bmw_rdy_flushe", 32'(FlushE), 32'd1);
        check_eq("bmw_rdy_stallf", 32'(StallF), 32'd0);
        tick();
        idle();
        #1;
`ifdef HAZARD_PERFCNT_EN
        check_eq("pc_flush_1", FlushCount,  32'd1);
        check_eq("pc_stall_b", StallCycles, 32'(exp_stall));
`endif

        // ---------------- branch beats load-use ----------------
        MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
        #1;
        check_eq("pri_stallf", 32'(StallF), 32'd0);
        check_eq("pri_flushd", 32'(FlushD), 32'd1);
        check_eq("pri_flushe", 32'(FlushE), 32'd1);
        tick();
        idle();
        #1;
`ifdef HAZARD_PERFCNT_EN
        check_eq("pc_flush_2", FlushCount, 32'd2);
`endif

        // ---------------- reset during MWAIT ----------------
        MemReqM = 1'b1; MemReadyM = 1'b0;
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        tick();
        check_eq("rm_state", 32'(dut.state_q), 32'(MWAIT));
        check_eq("rm_fwda_pre", 32'(ForwardAE), 32'd2);
        #2 reset = 1'b1;
        #1;
        check_eq("rm_busy",   32'(Busy),      32'd1);
        check_eq("rm_flushd", 32'(FlushD),    32'd1);
        check_eq("rm_flushe", 32'(FlushE),    32'd1);
        check_eq("rm_flushw", 32'(FlushW),    32'd1);
        check_eq("rm_stallf", 32'(StallF),    32'd0);
        check_eq("rm_stallm", 32'(StallM),    32'd0);
        check_eq("rm_fwda",   32'(ForwardAE), 32'd0);
`ifdef HAZARD_PERFCNT_EN
        check_eq("rm_cnt_stall", StallCycles, 32'd0);
        check_eq("rm_cnt_flush", FlushCount,  32'd0);
`endif
        tick();
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RV32 core. Drives stall and flush enables into the F/D, D/E, E/M and M/W pipeline registers, and drives the EX-stage forwarding selects. Handles four cases: post-reset pipeline clearing, load-use hazards, taken-branch flushes and data-memory wait states. Sits beside the datapath and observes only register indices, write enables and control strobes.

## Interface
Parameters:
- STARTUP_CYCLES, 1: cycles after reset release during which every pipeline register is held flushed; legal 1..15.
- CNT_W, 32: width of performance counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high.
- Rs1D, Rs2D  in  5  source registers of the instruction in D.
- Rs1E, Rs2E  in  5  source registers of the instruction in E.
- RdE  in  5  destination of the instruction in E.
- MemReadE  in  1  instruction in E is a load.
- RdM  in  5  destination of the instruction in M.
- RegWriteM  in  1  instruction in M writes the register file.
- RdW  in  5  destination of the instruction in W.
- RegWriteW  in  1  instruction in W writes the register file.
- PCSrcE  in  1  taken branch or jump resolved in E.
- MemReqM  in  1  load or store active in M.
- MemReadyM  in  1  data memory completes the M access this cycle.
- StallF, StallD, StallE, StallM  out  1  hold the PC or the named stage register.
- FlushD, FlushE, FlushW  out  1  load a bubble into the D, E or W register.
- ForwardAE, ForwardBE  out  2  EX operand selects: 00 register file, 01 ResultW, 10 ResultM.
- Busy  out  1  high while in INIT.
- StallCycles, FlushCount  out  CNT_W  present only with HAZARD_PERFCNT_EN.

## Operation
- FSM states: INIT, RUN, MWAIT. State resets to INIT. The startup counter resets to STARTUP_CYCLES-1.
- **INIT**
  - All Stall* = 0. FlushD = FlushE = FlushW = 1. Busy = 1. Forward* = 00.
  - Counter decrements each cycle. At 0 the FSM moves to RUN.
- **mem_stall** = MemReqM & ~MemReadyM.
  - In RUN, mem_stall drives StallF/D/E/M = 1 and FlushW = 1 in the same cycle, and the FSM moves to MWAIT.
  - In MWAIT, the same outputs hold while mem_stall = 1.
  - In MWAIT, the first cycle with MemReadyM = 1 deasserts the stalls combinationally, and the FSM returns to RUN.
- **Branch** (RUN or MWAIT, no mem_stall): PCSrcE drives FlushD = FlushE = 1.
- **Load-use** (no mem_stall, no PCSrcE): the hazard is MemReadE & RdE != 0 & (RdE == Rs1D | RdE == Rs2D). It drives StallF = StallD = 1 and FlushE = 1 for exactly one cycle.
- **Priority:** INIT > mem_stall > PCSrcE > load-use.
  - A branch that coincides with mem_stall stays held in E by StallE.
  - Its flush is issued in the first non-stalled cycle.
- **Forwarding** (RUN and MWAIT), shown for ForwardAE; ForwardBE is identical with Rs2E.
  - 10 if RegWriteM & RdM != 0 & RdM == Rs1E.
  - Else 01 if RegWriteW & RdW != 0 & RdW == Rs1E.
  - Else 00.
  - M always wins over W.
- Reset asserted in any state returns the FSM to INIT immediately. Outputs take INIT values asynchronously.

## Timing
- State and counters update on the rising edge of clk.
- All stall, flush and forward outputs are combinational from state and current inputs, so hazards take effect with zero latency.
- After reset falls, flushes are asserted for exactly STARTUP_CYCLES rising edges. The first RUN cycle follows.
- A load-use stall costs one cycle. A branch costs two squashed slots. A memory wait costs one cycle per cycle with MemReadyM = 0.

## Configuration
- **HAZARD_PERFCNT_EN defined:**
  - StallCycles increments in every RUN/MWAIT cycle with StallF = 1.
  - FlushCount increments on every branch flush.
  - Both counters saturate at all-ones and reset to 0.
- **Undefined:** both ports and all counter logic are absent.

## Structure
- Shared package e5_pipe_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - hz_state_t enum: INIT, RUN, MWAIT.
  - Register index width constant REG_IDX_W = 5.
- Sub-module hazard_fwd_unit: purely combinational, computes ForwardAE and ForwardBE. It is instantiated once, and its outputs are overridden to 00 in INIT.

## Test plan
- **Startup:** STARTUP_CYCLES = 3, pulse reset high then release → FlushD/E/W = 1 and Busy = 1 for 3 edges, then 0 in RUN.
- **Forwarding:** RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5 → ForwardAE = 10. With RdM = 0 → ForwardAE = 01. With Rs2E = 0 and RdW = 0 → ForwardBE = 00.
- **Load-use:** MemReadE = 1, RdE = 7, Rs2D = 7 → StallF = StallD = FlushE = 1 for one cycle. RdE = 0 gives no stall.
- **Memory wait:** MemReqM = 1, MemReadyM = 0 for 3 cycles then 1 → StallF/D/E/M = FlushW = 1 for exactly 3 cycles; FSM in MWAIT, then RUN.
- **Branch during memory wait:** PCSrcE = 1 during MWAIT → no FlushD/E while stalled. FlushD = FlushE = 1 in the ready cycle. With the macro defined, FlushCount = 1.
- **Reset mid-operation:** reset asserted during MWAIT → outputs take INIT values immediately. Counters read 0.
